// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits), overlap/non-overlap, saturating match count.
// Optional macro SEQDET_REG_OUT_EN registers the detected pulse (one cycle later); default is a combinational Mealy output.
module seq_detector_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN = 4,
  parameter int                 LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_i,
  input  logic               in_valid_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cnt_clr_i,
  output logic               detected_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               cfg_err_o
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, hist_q, hist_d, mask;
  logic [LEN_W-1:0]   len_q, fill_q, fill_d;
  logic               ovl_q, err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, fill_ok, match;
  logic [LEN_W:0]     fill_inc;

  assign accept   = in_valid_i & ~cfg_load_i & ~rst_i;
  assign hist_d   = {hist_q[MAX_LEN-2:0], in_i};
  assign fill_inc = {1'b0, fill_q} + 1'b1;
  assign fill_ok  = fill_inc >= {1'b0, len_q};

  // Only the low len_q bits of the pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
  end

  assign match = accept & ~err_q & fill_ok & (((hist_d ^ pat_q) & mask) == '0);
  assign err_d = (cfg_len_i == '0) || (cfg_len_i > MAX_FILL);

  always_comb begin
    fill_d = fill_q;
    if (cfg_load_i)               fill_d = '0;
    else if (accept) begin
      if (match && !ovl_q)        fill_d = '0;
      else if (fill_q != MAX_FILL) fill_d = fill_inc[LEN_W-1:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                cnt_d = '0;
    else if (match && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b1;
      err_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (cfg_load_i) begin
        pat_q  <= cfg_pattern_i;
        len_q  <= cfg_len_i;
        ovl_q  <= cfg_overlap_i;
        err_q  <= err_d;
        hist_q <= '0;
      end else if (accept) begin
        hist_q <= hist_d;
      end
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SEQDET_REG_OUT_EN
  logic det_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) det_q <= 1'b0;
    else       det_q <= match;
  end
  assign detected_o = det_q;
`else
  assign detected_o = match;
`endif

  assign match_count_o = cnt_q;
  assign cfg_err_o     = err_q;

endmodule
